// File: rtl/program_loader_if.sv
// Byte-stream handshake plus instruction-memory write bus for the program loader.
// master: stream producer / memory side. slave: the loader itself.
// Widths follow the loader parameters; the stream is always one byte wide.
interface program_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 24
);
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_data
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_data
  );
endinterface

// File: rtl/program_loader.sv
// Boot loader: packs a byte stream into 3-byte words, writes CPU memory, checks XOR sum.
// Latency: the B2 byte accepted at edge k shows MemWE=1 in cycle k..k+1; 4 cycles/word.
// Backpressure: byte_ready is low in IDLE/WRITE/RUN/ERROR; offered bytes wait there.
module program_loader #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  program_loader_if.slave       bus,
  output logic                  o_cpu_reset_n,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_COUNT = 4'd1,
    S_B0    = 4'd2,
    S_B1    = 4'd3,
    S_B2    = 4'd4,
    S_WRITE = 4'd5,
    S_CHECK = 4'd6,
    S_RUN   = 4'd7,
    S_ERROR = 4'd8
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  // Datapath registers. A count byte of 0 means 2^ADDR_W words, which falls
  // out naturally because the last index is compared as count-1 modulo 2^ADDR_W.
  logic [ADDR_W-1:0]   r_count;
  logic [ADDR_W-1:0]   r_index;
  logic [DATA_W-1:0]   r_word;
  logic [7:0]          r_acc;

  // Registered outputs
  logic                r_byte_ready;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_data;
  logic                r_cpu_reset_n;
  logic                r_busy;
  logic                r_done;
  logic                r_error;

  // Next values of the registered outputs, decoded from the next state
  logic                w_byte_ready;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_data;
  logic                w_cpu_reset_n;
  logic                w_busy;
  logic                w_done;
  logic                w_error;

  logic                w_xfer;
  logic                w_last;

  assign w_xfer = bus.byte_valid & r_byte_ready;
  assign w_last = (r_index == (r_count - ADDR_W'(1)));

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state decode; Start only matters in IDLE and ERROR
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next_state = S_COUNT;
      S_COUNT: if (w_xfer)  w_next_state = S_B0;
      S_B0:    if (w_xfer)  w_next_state = S_B1;
      S_B1:    if (w_xfer)  w_next_state = S_B2;
      S_B2:    if (w_xfer)  w_next_state = S_WRITE;
      S_WRITE: w_next_state = w_last ? S_CHECK : S_B0;
      S_CHECK: if (w_xfer)  w_next_state = (bus.byte_in == r_acc) ? S_RUN : S_ERROR;
      S_RUN:   w_next_state = S_RUN;
      S_ERROR: if (i_start) w_next_state = S_COUNT;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode: computed from the next state so the registered outputs line
  // up with the state they describe. The written word takes its low byte straight
  // from the stream because r_word is only updated on the same edge.
  always_comb begin
    w_byte_ready  = 1'b0;
    w_mem_we      = 1'b0;
    w_mem_addr    = r_mem_addr;
    w_mem_data    = r_mem_data;
    w_cpu_reset_n = 1'b0;
    w_busy        = 1'b0;
    w_done        = 1'b0;
    w_error       = 1'b0;
    case (w_next_state)
      S_COUNT, S_B0, S_B1, S_B2, S_CHECK: begin
        w_byte_ready = 1'b1;
        w_busy       = 1'b1;
      end
      S_WRITE: begin
        w_mem_we   = 1'b1;
        w_busy     = 1'b1;
        w_mem_addr = r_index;
        w_mem_data = {r_word[DATA_W-1:8], bus.byte_in};
      end
      S_RUN: begin
        w_done        = 1'b1;
        w_cpu_reset_n = 1'b1;
      end
      S_ERROR: w_error = 1'b1;
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_byte_ready  <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_data    <= '0;
      r_cpu_reset_n <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_byte_ready  <= w_byte_ready;
      r_mem_we      <= w_mem_we;
      r_mem_addr    <= w_mem_addr;
      r_mem_data    <= w_mem_data;
      r_cpu_reset_n <= w_cpu_reset_n;
      r_busy        <= w_busy;
      r_done        <= w_done;
      r_error       <= w_error;
    end
  end

  // Word assembly, checksum accumulation and word index
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_index <= '0;
      r_word  <= '0;
      r_acc   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_ERROR: if (i_start) r_index <= '0;
        S_COUNT: if (w_xfer) begin
          r_count <= ADDR_W'(bus.byte_in);
          r_acc   <= '0;
          r_index <= '0;
        end
        S_B0: if (w_xfer) begin
          r_word[23:16] <= bus.byte_in;
          r_acc         <= r_acc ^ bus.byte_in;
        end
        S_B1: if (w_xfer) begin
          r_word[15:8] <= bus.byte_in;
          r_acc        <= r_acc ^ bus.byte_in;
        end
        S_B2: if (w_xfer) begin
          r_word[7:0] <= bus.byte_in;
          r_acc       <= r_acc ^ bus.byte_in;
        end
        S_WRITE: if (!w_last) r_index <= r_index + ADDR_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.byte_ready = r_byte_ready;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_data   = r_mem_data;
  assign o_cpu_reset_n  = r_cpu_reset_n;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_error        = r_error;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: byte streams with hand-computed words and checksums.
// A passive monitor records memory writes and accepted transfers for the checks.
module tb_program_loader;
  logic clk;
  logic rst_n;
  logic start;
  logic cpu_reset_n, busy, done, error;

  int n_checks = 0;
  int n_fail   = 0;

  program_loader_if #(.ADDR_W(8), .DATA_W(24)) u_if ();

  program_loader #(.DATA_W(24), .ADDR_W(8)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .bus           (u_if.slave),
    .o_cpu_reset_n (cpu_reset_n),
    .o_busy        (busy),
    .o_done        (done),
    .o_error       (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model and transfer/write counters
  logic [23:0] mem [256];
  int          xfer_cnt = 0;
  int          we_cnt   = 0;
  logic [7:0]  last_addr;
  logic [23:0] last_data;

  always @(posedge clk) begin
    if (rst_n && u_if.byte_valid && u_if.byte_ready) xfer_cnt++;
    if (u_if.mem_we) begin
      mem[u_if.mem_addr] = u_if.mem_data;
      last_addr = u_if.mem_addr;
      last_data = u_if.mem_data;
      we_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer a byte (called at a negedge); returns at the negedge after its transfer.
  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    u_if.byte_in    = b;
    u_if.byte_valid = 1'b1;
    while (!u_if.byte_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("send_timeout", 32'(t), 32'd0);
    @(negedge clk);
  endtask

  task automatic gap();
    int g;
    g = int'($urandom_range(0, 3));
    if (g != 0) begin
      u_if.byte_valid = 1'b0;
      repeat (g) @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    u_if.byte_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, 32'(u_if.byte_ready), 32'd0);
    check({tag, "_we"},    32'(u_if.mem_we),     32'd0);
    check({tag, "_addr"},  32'(u_if.mem_addr),   32'd0);
    check({tag, "_data"},  32'(u_if.mem_data),   32'd0);
    check({tag, "_cpurn"}, 32'(cpu_reset_n),     32'd0);
    check({tag, "_busy"},  32'(busy),            32'd0);
    check({tag, "_done"},  32'(done),            32'd0);
    check({tag, "_error"}, 32'(error),           32'd0);
  endtask

  logic [7:0] good_stream [8];
  int xb, wb;

  initial begin
    good_stream[0] = 8'h02; good_stream[1] = 8'h12; good_stream[2] = 8'h34;
    good_stream[3] = 8'h56; good_stream[4] = 8'hAB; good_stream[5] = 8'hCD;
    good_stream[6] = 8'hEF; good_stream[7] = 8'hF9;
    rst_n = 1'b0; start = 1'b0;
    u_if.byte_in = 8'h00; u_if.byte_valid = 1'b0;
    @(negedge clk);
    do_reset();
    check_reset_vals("rst");

    // 1: gap-free load, valid held high through the WRITE cycles
    xb = xfer_cnt; wb = we_cnt;
    pulse_start();
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_ready", 32'(u_if.byte_ready), 32'd1);
    for (int i = 0; i < 4; i++) send_byte(good_stream[i]);
    check("t1_we0", 32'(u_if.mem_we), 32'd1);
    check("t1_addr0", 32'(u_if.mem_addr), 32'h00);
    check("t1_data0", 32'(u_if.mem_data), 32'h123456);
    check("t1_rdy_in_write", 32'(u_if.byte_ready), 32'd0);
    for (int i = 4; i < 8; i++) send_byte(good_stream[i]);
    check("t1_mem0", 32'(mem[0]), 32'h123456);
    check("t1_mem1", 32'(mem[1]), 32'hABCDEF);
    check("t1_we_cycles", 32'(we_cnt - wb), 32'd2);
    check("t1_xfers", 32'(xfer_cnt - xb), 32'd8);
    check("t1_done", 32'(done), 32'd1);
    check("t1_cpurn", 32'(cpu_reset_n), 32'd1);
    check("t1_busy_end", 32'(busy), 32'd0);
    check("t1_ready_end", 32'(u_if.byte_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("t1_xfers_run", 32'(xfer_cnt - xb), 32'd8);

    // 2: bad checksum, then retry from ERROR
    do_reset();
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(good_stream[i]);
    send_byte(8'h00);
    check("t2_error", 32'(error), 32'd1);
    check("t2_done", 32'(done), 32'd0);
    check("t2_cpurn", 32'(cpu_reset_n), 32'd0);
    check("t2_busy", 32'(busy), 32'd0);
    u_if.byte_valid = 1'b0;
    pulse_start();
    check("t2_err_clr", 32'(error), 32'd0);
    check("t2_busy_retry", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) send_byte(good_stream[i]);
    check("t2_done_retry", 32'(done), 32'd1);
    check("t2_error_retry", 32'(error), 32'd0);

    // 3: random valid gaps
    do_reset();
    mem[0] = 24'h0; mem[1] = 24'h0;
    xb = xfer_cnt;
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      gap();
      send_byte(good_stream[i]);
    end
    check("t3_mem0", 32'(mem[0]), 32'h123456);
    check("t3_mem1", 32'(mem[1]), 32'hABCDEF);
    check("t3_xfers", 32'(xfer_cnt - xb), 32'd8);
    check("t3_done", 32'(done), 32'd1);

    // 4: count 0 -> 256 words, word i = {i,i,i}; XOR of all payload is 0
    do_reset();
    wb = we_cnt;
    pulse_start();
    send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i)); send_byte(8'(i)); send_byte(8'(i));
    end
    send_byte(8'h00);
    check("t4_writes", 32'(we_cnt - wb), 32'd256);
    check("t4_last_addr", 32'(last_addr), 32'hFF);
    check("t4_last_data", 32'(last_data), 32'hFFFFFF);
    check("t4_mem80", 32'(mem[8'h80]), 32'h808080);
    check("t4_done", 32'(done), 32'd1);

    // 5: reset mid-load after B1 of word 1, with a byte offered in the reset cycle
    do_reset();
    mem[0] = 24'h0;
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(good_stream[i]);
    xb = xfer_cnt; wb = we_cnt;
    u_if.byte_in = 8'hEF; u_if.byte_valid = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    u_if.byte_valid = 1'b0;
    check_reset_vals("t5");
    check("t5_no_xfer", 32'(xfer_cnt - xb), 32'd0);
    check("t5_no_we", 32'(we_cnt - wb), 32'd0);
    check("t5_mem0_kept", 32'(mem[0]), 32'h123456);
    pulse_start();
    send_byte(8'h01); send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h0C);
    send_byte(8'h0D);
    check("t5_mem0_new", 32'(mem[0]), 32'h0A0B0C);
    check("t5_done", 32'(done), 32'd1);

    // 6: Start pulses while busy and in RUN are ignored
    do_reset();
    pulse_start();
    pulse_start();
    check("t6_count_busy", 32'(busy), 32'd1);
    check("t6_count_rdy", 32'(u_if.byte_ready), 32'd1);
    send_byte(8'h01);
    send_byte(8'h11);
    u_if.byte_valid = 1'b0;
    pulse_start();
    check("t6_b1_rdy", 32'(u_if.byte_ready), 32'd1);
    send_byte(8'h22);
    send_byte(8'h33);
    check("t6_in_write", 32'(u_if.mem_we), 32'd1);
    u_if.byte_valid = 1'b0;
    pulse_start();
    check("t6_check_rdy", 32'(u_if.byte_ready), 32'd1);
    check("t6_check_busy", 32'(busy), 32'd1);
    send_byte(8'h00);
    check("t6_mem0", 32'(mem[0]), 32'h112233);
    check("t6_done", 32'(done), 32'd1);
    u_if.byte_valid = 1'b0;
    pulse_start();
    @(negedge clk);
    check("t6_run_done", 32'(done), 32'd1);
    check("t6_run_busy", 32'(busy), 32'd0);
    check("t6_run_cpurn", 32'(cpu_reset_n), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
